// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq: multi-cycle unsigned ALU for the calculator datapath.
//   add / subtract finish at the accept edge; multiply (shift-add) and
//   divide (restoring) iterate one bit per clock for WIDTH clocks.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high; aborts any running operation
//   regA, regB     operands (A = dividend/multiplicand, B = divisor/multiplier)
//   opcode         00 add, 01 subtract, 10 multiply, 11 divide
//   computestrobe  start request, only looked at while idle
//   result         sum / difference / low product / quotient
//   remainder      division remainder, 0 for the other operations
//   ovf            carry / borrow / product overflow / divide-by-zero
//   busy           high while a multiply or divide is iterating
//   done           one-cycle pulse after result/remainder/ovf update
//   fsm_state      current state (0 IDLE, 1 MUL, 2 DIV) for observation
//
// Handshake: an operation is accepted on a rising edge where
// computestrobe=1 and the block is idle (busy=0). Strobes while busy are
// dropped, not queued. done is high for exactly the one cycle after the
// edge that wrote the outputs; that cycle is idle, so a new strobe there is
// accepted (back-to-back operation).
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] regA,
  input  logic [WIDTH-1:0] regB,
  input  logic [1:0]       opcode,
  input  logic             computestrobe,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITER = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t state;

  // Iteration registers, kept apart from the visible outputs so that the
  // previous result stays stable while an operation runs.
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;       // product accumulator
  logic [2*WIDTH-1:0] mcand;     // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier;    // multiplier, shifted right each step
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   part_rem;  // partial remainder
  logic [WIDTH-1:0]   quo;       // dividend bits shift out MSB-first, quotient bits shift in

  // Combinational step values
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  always_comb begin
    add_sum   = {1'b0, regA} + {1'b0, regB};
    sub_diff  = {1'b0, regA} - {1'b0, regB};   // MSB is the borrow
    mul_next  = acc + (mplier[0] ? mcand : '0);
    div_shift = {part_rem, quo[WIDTH-1]};
    div_trial = div_shift - {1'b0, divisor};
    // Partial remainder is always below the divisor, so the trial
    // difference is negative exactly when its top bit is set.
    div_ge    = ~div_trial[WIDTH];
    rem_next  = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], div_ge};
  end

  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      result    <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      divisor   <= '0;
      part_rem  <= '0;
      quo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (computestrobe) begin
            case (opcode)
              2'b00: begin
                result    <= add_sum[WIDTH-1:0];
                ovf       <= add_sum[WIDTH];
                remainder <= '0;
                done      <= 1'b1;
              end
              2'b01: begin
                result    <= sub_diff[WIDTH-1:0];
                ovf       <= sub_diff[WIDTH];
                remainder <= '0;
                done      <= 1'b1;
              end
              2'b10: begin
                state  <= MUL;
                busy   <= 1'b1;
                cnt    <= ITER;
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, regA};
                mplier <= regB;
              end
              default: begin
                if (regB == '0) begin
                  // Divide by zero resolves immediately, no iteration.
                  result    <= '1;
                  remainder <= regA;
                  ovf       <= 1'b1;
                  done      <= 1'b1;
                end else begin
                  state    <= DIV;
                  busy     <= 1'b1;
                  cnt      <= ITER;
                  divisor  <= regB;
                  part_rem <= '0;
                  quo      <= regA;
                end
              end
            endcase
          end
        end

        MUL: begin
          acc    <= mul_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result    <= mul_next[WIDTH-1:0];
            ovf       <= |mul_next[2*WIDTH-1:WIDTH];
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end

        DIV: begin
          part_rem <= rem_next;
          quo      <= quo_next;
          cnt      <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result    <= quo_next;
            remainder <= rem_next;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq: table-driven check of alu_seq at WIDTH=8 and WIDTH=16, plus
// hand sequences for strobe-while-busy, back-to-back and reset abort.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- WIDTH=8 instance ----------------
  logic [7:0]  a8, b8, res8, rem8;
  logic [1:0]  op8, st8;
  logic        strobe8, ovf8, busy8, done8;

  alu_seq #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(reset), .regA(a8), .regB(b8), .opcode(op8),
    .computestrobe(strobe8), .result(res8), .remainder(rem8), .ovf(ovf8),
    .busy(busy8), .done(done8), .fsm_state(st8)
  );

  // ---------------- WIDTH=16 instance ----------------
  logic [15:0] a16, b16, res16, rem16;
  logic [1:0]  op16, st16;
  logic        strobe16, ovf16, busy16, done16;

  alu_seq #(.WIDTH(16)) dut16 (
    .clock(clk), .reset(reset), .regA(a16), .regB(b16), .opcode(op16),
    .computestrobe(strobe16), .result(res16), .remainder(rem16), .ovf(ovf16),
    .busy(busy16), .done(done16), .fsm_state(st16)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wide;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [15:0] res, rem;
    logic        ovf;
    int          lat;   // edges from accept edge to completing edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit w, logic [1:0] op, logic [15:0] a, logic [15:0] b,
                              logic [15:0] res, logic [15:0] rem, logic ovf, int lat);
    vec_t v;
    v.wide = w; v.op = op; v.a = a; v.b = b;
    v.res = res; v.rem = rem; v.ovf = ovf; v.lat = lat;
    return v;
  endfunction

  // ---------------- driver ----------------
  logic [15:0] s_res, s_rem;
  logic        s_ovf, s_busy_first, s_done;
  logic [1:0]  s_state_first;
  int          s_lat;

  task automatic sample(input bit wide);
    s_res  = wide ? res16 : {8'h0, res8};
    s_rem  = wide ? rem16 : {8'h0, rem8};
    s_ovf  = wide ? ovf16 : ovf8;
    s_done = wide ? done16 : done8;
  endtask

  // Drive one operation, wait (bounded) for done, capture outputs.
  task automatic do_op(input bit wide, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    if (wide) begin a16 = a; b16 = b; op16 = op; strobe16 = 1'b1; end
    else      begin a8 = a[7:0]; b8 = b[7:0]; op8 = op; strobe8 = 1'b1; end
    @(posedge clk); #1;
    strobe8 = 1'b0; strobe16 = 1'b0;
    s_busy_first  = wide ? busy16 : busy8;
    s_state_first = wide ? st16 : st8;
    s_lat = 0;
    sample(wide);
    while (!s_done && s_lat < 40) begin
      @(posedge clk); #1;
      s_lat++;
      sample(wide);
    end
  endtask

  initial begin
    a8 = '0; b8 = '0; op8 = '0; strobe8 = 1'b0;
    a16 = '0; b16 = '0; op16 = '0; strobe16 = 1'b0;
    reset = 1'b1;

    //               wide op     a      b      res    rem  ovf lat
    vecs.push_back(mk(0, 2'd0, 200,   100,   44,    0,   1,  0));
    vecs.push_back(mk(0, 2'd0, 3,     4,     7,     0,   0,  0));
    vecs.push_back(mk(0, 2'd0, 255,   1,     0,     0,   1,  0));
    vecs.push_back(mk(0, 2'd1, 5,     7,     254,   0,   1,  0));
    vecs.push_back(mk(0, 2'd1, 7,     5,     2,     0,   0,  0));
    vecs.push_back(mk(0, 2'd1, 9,     9,     0,     0,   0,  0));
    vecs.push_back(mk(0, 2'd2, 15,    17,    255,   0,   0,  8));
    vecs.push_back(mk(0, 2'd2, 16,    16,    0,     0,   1,  8));
    vecs.push_back(mk(0, 2'd2, 255,   0,     0,     0,   0,  8));
    vecs.push_back(mk(0, 2'd2, 255,   255,   1,     0,   1,  8));
    vecs.push_back(mk(0, 2'd3, 200,   7,     28,    4,   0,  8));
    vecs.push_back(mk(0, 2'd3, 9,     0,     255,   9,   1,  0));
    vecs.push_back(mk(0, 2'd3, 5,     9,     0,     5,   0,  8));
    vecs.push_back(mk(0, 2'd3, 255,   1,     255,   0,   0,  8));
    vecs.push_back(mk(0, 2'd0, 1,     1,     2,     0,   0,  0));
    vecs.push_back(mk(1, 2'd2, 300,   300,   24464, 0,   1,  16));
    vecs.push_back(mk(1, 2'd3, 65535, 255,   257,   0,   0,  16));
    vecs.push_back(mk(1, 2'd0, 65535, 2,     1,     0,   1,  0));

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset result8", res8, 0);
    check("reset remainder8", rem8, 0);
    check("reset ovf8", ovf8, 0);
    check("reset busy8", busy8, 0);
    check("reset done8", done8, 0);
    check("reset state8", st8, 0);
    check("reset result16", res16, 0);

    // ---- table ----
    foreach (vecs[i]) begin
      do_op(vecs[i].wide, vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d latency", i), s_lat, vecs[i].lat);
      check($sformatf("v%0d result", i), s_res, vecs[i].res);
      check($sformatf("v%0d remainder", i), s_rem, vecs[i].rem);
      check($sformatf("v%0d ovf", i), s_ovf, vecs[i].ovf);
      check($sformatf("v%0d busy", i), s_busy_first, (vecs[i].lat > 0));
      check($sformatf("v%0d state", i), s_state_first,
            (vecs[i].lat == 0) ? 0 : ((vecs[i].op == 2'd2) ? 1 : 2));
      @(posedge clk); #1;
      sample(vecs[i].wide);
      check($sformatf("v%0d done width", i), s_done, 0);
    end

    // ---- strobe held during mul, changing inputs, then back-to-back add ----
    begin
      logic [7:0] prev;
      int lat;
      prev = res8;
      a8 = 15; b8 = 17; op8 = 2'd2; strobe8 = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!done8 && lat < 40) begin
        a8 = a8 + 8'd3;
        op8 = 2'd0;
        if (lat == 4) check("held mid result", res8, prev);
        @(posedge clk); #1;
        lat++;
      end
      check("held latency", lat, 8);
      check("held product", res8, 255);
      check("held ovf", ovf8, 0);
      // done cycle: strobe still high, new add must be accepted
      a8 = 3; b8 = 17; op8 = 2'd0;
      @(posedge clk); #1;
      strobe8 = 1'b0;
      check("b2b done", done8, 1);
      check("b2b result", res8, 20);
      check("b2b ovf", ovf8, 0);
    end

    // ---- reset in the middle of a divide ----
    a8 = 200; b8 = 7; op8 = 2'd3; strobe8 = 1'b1;
    @(posedge clk); #1;
    strobe8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset busy", busy8, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort result", res8, 0);
    check("abort remainder", rem8, 0);
    check("abort ovf", ovf8, 0);
    check("abort busy", busy8, 0);
    check("abort done", done8, 0);
    check("abort state", st8, 0);
    repeat (10) begin
      @(posedge clk); #1;
      check("abort no done", done8, 0);
    end
    do_op(0, 2'd3, 200, 7);
    check("post-reset latency", s_lat, 8);
    check("post-reset quotient", s_res, 28);
    check("post-reset remainder", s_rem, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
